// File: rtl/perip_arbiter_pkg.sv
// Shared definitions for the GPIO peripheral-port arbiter: FSM encodings,
// the default address window and the window check.
package perip_arbiter_pkg;

   localparam logic [3:0] PERIP_BASE_NIB = 4'h3;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_e;

   // True when the top address nibble falls outside the peripheral window.
   function automatic logic nib_mismatch(input logic [3:0] nib, input logic [3:0] base);
      return (nib != base);
   endfunction

endpackage

// File: rtl/perip_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; prio names the master favoured on a tie.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt,
   output logic       winner
);

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      winner = 1'b0;
      gnt    = 2'b00;
      unique case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = prio;
         default: winner = 1'b0;
      endcase
      if (|req) gnt = winner ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/perip_arbiter.sv
// Two-master arbiter/sequencer for the GPIO register port: one slave access per grant,
// response two cycles later to line up with the slave's registered read data.
module perip_arbiter
   import perip_arbiter_pkg::*;
#(
   parameter int         ADDR_W   = 32,
   parameter int         DATA_W   = 32,
   parameter logic [3:0] BASE_NIB = PERIP_BASE_NIB
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          m_req_i,
   input  logic [1:0]          m_we_i,
   input  logic [2*ADDR_W-1:0] m_addr_i,
   input  logic [2*DATA_W-1:0] m_wdata_i,
   output logic [1:0]          m_gnt_o,
   output logic [1:0]          m_rvalid_o,
   output logic                m_err_o,
   output logic [DATA_W-1:0]   m_rdata_o,
   output logic                wr_en_o,
   output logic [ADDR_W-1:0]   wr_addr_o,
   output logic [DATA_W-1:0]   wr_data_o,
   output logic [ADDR_W-1:0]   rd_addr_o,
   input  logic [DATA_W-1:0]   rd_data_i
);

   arb_state_e          r_state;
   arb_state_e          w_next;
   logic                r_prio;
   logic                r_owner;
   logic                r_cap_we;
   logic                r_cap_err;
   logic [ADDR_W-1:0]   r_cap_addr;
   logic [DATA_W-1:0]   r_cap_wdata;

   logic [1:0]          w_arb_gnt;
   logic                w_winner;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req    (m_req_i),
      .prio   (r_prio),
      .gnt    (w_arb_gnt),
      .winner (w_winner)
   );

   assign w_sel_we    = w_winner ? m_we_i[1] : m_we_i[0];
   assign w_sel_addr  = w_winner ? m_addr_i[2*ADDR_W-1:ADDR_W]  : m_addr_i[ADDR_W-1:0];
   assign w_sel_wdata = w_winner ? m_wdata_i[2*DATA_W-1:DATA_W] : m_wdata_i[DATA_W-1:0];

   // Grant is the only combinational output; it is visible in IDLE alone.
   always_comb begin
      w_next  = r_state;
      m_gnt_o = 2'b00;
      unique case (r_state)
         ARB_IDLE: begin
            m_gnt_o = w_arb_gnt;
            if (|m_req_i) w_next = ARB_ISSUE;
         end
         ARB_ISSUE: w_next = ARB_RESP;
         ARB_RESP:  w_next = ARB_IDLE;
         default:   w_next = ARB_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_prio      <= 1'b0;
         r_owner     <= 1'b0;
         r_cap_we    <= 1'b0;
         r_cap_err   <= 1'b0;
         r_cap_addr  <= '0;
         r_cap_wdata <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ARB_IDLE && |m_req_i) begin
            r_owner     <= w_winner;
            r_cap_we    <= w_sel_we;
            r_cap_addr  <= w_sel_addr;
            r_cap_wdata <= w_sel_wdata;
            r_cap_err   <= nib_mismatch(w_sel_addr[ADDR_W-1 -: 4], BASE_NIB);
         end
         if (r_state == ARB_RESP) r_prio <= ~r_owner;
      end
   end

   // Out-of-window writes never strobe the slave; the harmless read still happens but is masked.
   assign wr_en_o    = (r_state == ARB_ISSUE) && r_cap_we && !r_cap_err;
   assign wr_addr_o  = r_cap_addr;
   assign rd_addr_o  = r_cap_addr;
   assign wr_data_o  = r_cap_wdata;
   assign m_rvalid_o = (r_state == ARB_RESP) ? {r_owner, ~r_owner} : 2'b00;
   assign m_err_o    = (r_state == ARB_RESP) && r_cap_err;
   assign m_rdata_o  = (r_state == ARB_RESP && !r_cap_we && !r_cap_err) ? rd_data_i : '0;

endmodule

// File: doc/perip_arbiter.md
# perip_arbiter

Two-master arbiter and sequencer for the peripheral register port of the GPIO block. It shares the single write/read port between master 0 (core load/store path) and master 1 (UART debug loader). Each accepted request becomes exactly one register access, sequenced so that the GPIO's one-cycle registered read data is captured correctly. Accesses outside the peripheral's address window are rejected with an error and never reach the slave.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `BASE_NIB`, default 4'h3: required value of `addr[ADDR_W-1:ADDR_W-4]` for an access to be legal.

Ports (reset-timing terms are defined under Timing):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m_req_i`  in  2  request, one bit per master.
- `m_we_i`  in  2  1 = write, 0 = read.
- `m_addr_i`  in  2*ADDR_W  master k uses bits `[k*ADDR_W +: ADDR_W]`.
- `m_wdata_i`  in  2*DATA_W  write data, packed the same way.
- `m_gnt_o`  out  2  one-hot grant pulse; combinational in IDLE.
- `m_rvalid_o`  out  2  one-hot completion pulse.
- `m_err_o`  out  1  with `m_rvalid_o`: 1 = address out of window.
- `m_rdata_o`  out  DATA_W  read data, valid with `m_rvalid_o`.
- `wr_en_o`  out  1  slave write enable.
- `wr_addr_o`  out  ADDR_W  slave write address.
- `wr_data_o`  out  DATA_W  slave write data.
- `rd_addr_o`  out  ADDR_W  slave read address.
- `rd_data_i`  in  DATA_W  slave read data, registered by the slave one cycle after `rd_addr_o`.

## Operation
- FSM states: IDLE, ISSUE, RESP. Transitions: IDLE→ISSUE on any `m_req_i`; ISSUE→RESP unconditionally; RESP→IDLE unconditionally.
- Per-transaction holding registers: `owner`, `cap_we`, `cap_addr`, `cap_wdata`, `cap_err`. `cap_err = (addr[ADDR_W-1:ADDR_W-4] != BASE_NIB)`.
- **IDLE:** the winner is chosen round-robin using pointer `prio` (the master favoured on a tie).
  - Only one request: that master wins.
  - Both requesting: master `prio` wins.
  - `m_gnt_o[winner]` is 1 in the same cycle. The winner's fields are captured at the clock edge.
- **ISSUE:** if `!cap_err`:
  - `wr_en_o = cap_we`.
  - `wr_addr_o = rd_addr_o = cap_addr`.
  - `wr_data_o = cap_wdata`.
  - If `cap_err`, `wr_en_o` stays 0.
- **RESP:**
  - `m_rvalid_o[owner] = 1`, `m_err_o = cap_err`.
  - `m_rdata_o = rd_data_i` for a legal read, else 0.
  - `prio <= ~owner` at the RESP edge.
- Master contract: hold `req`/`we`/`addr`/`wdata` stable until the cycle of `gnt`. After `gnt`, the master may change or drop them. Dropping `req` before `gnt` withdraws the request.
- A master may re-request in the IDLE cycle after its own RESP. If the other master is also requesting, the other master wins.
- Writes and errored accesses still complete with `m_rvalid_o`, giving exactly one completion per grant.

## Timing
- Reset values: state = IDLE, `prio` = 0, all captured registers = 0.
  - All outputs 0 except the address/data buses, which reflect `cap_addr`/`cap_wdata` = 0.
  - Reset mid-transaction drops the transaction: no `m_rvalid_o`, no `wr_en_o`.
- Latency: grant in cycle T, `wr_en_o` in T+1, `m_rvalid_o` in T+2.
- Throughput: at most one access per 3 cycles.
- `rd_addr_o` holds `cap_addr` through ISSUE and RESP. The slave registers its read data at the end of T+1, so `rd_data_i` is valid during T+2.
- `wr_en_o` is high for exactly one cycle per legal write and is never high outside ISSUE.
- Requests arriving during ISSUE/RESP are ignored until IDLE; requests are never queued.
- Simultaneous first requests after reset: master 0 wins.
- Continuous requests from both masters: grants alternate 0,1,0,1,…; no master is granted twice in a row while the other waits.
- `m_gnt_o` is the only combinational output, from `state` and `m_req_i`. All other outputs come from registers or `rd_data_i`.

## Structure
- Shared defines file (alongside the existing `ZERO_WORD`): state encodings `ARB_IDLE` / `ARB_ISSUE` / `ARB_RESP` (2 bits) and the default `PERIP_BASE_NIB`.
- One sub-module, `rr_arb2`: a combinational 2-way round-robin picker with inputs `req[1:0]`, `prio` and outputs `gnt[1:0]`, `winner`.
- Top level contains the FSM, the capture registers and the slave/response muxing.

## Test plan
- Master 0 writes 0x0000_000A to 0x3000_0004, then master 0 reads 0x3000_0004:
  - `wr_en_o` is high in T+1 only, with `wr_data_o` = 0x0000_000A.
  - The read returns `m_rdata_o` = 0x0000_000A with `m_rvalid_o` = 2'b01 at T+2 and `m_err_o` = 0.
- Both masters request continuously for 8 grants:
  - Grant order is 0,1,0,1,0,1,0,1.
  - Each `m_rvalid_o` arrives exactly 2 cycles after its grant.
- Master 1 writes 0x5 to 0x4000_0004:
  - `m_err_o` = 1 with `m_rvalid_o` = 2'b10.
  - `wr_en_o` never asserts; a later read of 0x3000_0004 returns the old value.
- Master 1 requests during master 0's ISSUE cycle: master 1 is granted in the IDLE cycle following master 0's RESP (T+3).
- `rst` asserted in the ISSUE cycle of a write:
  - No `wr_en_o`, no `m_rvalid_o`.
  - After release, state is IDLE, `prio` = 0, and a simultaneous request grants master 0.
- Master 0 raises and drops `req` while master 1 holds the port:
  - No grant to master 0.
  - The completion count equals the grant count.
